// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- MEM-stage load/store unit between the EX/MEM register and datamem.
//
// Turns byte / halfword / word requests into accesses on the big-endian,
// byte-addressed 32-bit word port of datamem. The byte at the request address
// is the most significant byte of that port. Loads are sign- or zero-extended.
// Sub-word stores go through a registered read-modify-write sequence
// (IDLE -> RMW_RD -> RMW_WR). The unit stalls the pipeline while that
// sequence runs.
//
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   defined   : misaligned half/word accesses complete in one cycle with fault=1,
//               resp_rdata=0, and never write memory.
//   undefined : fault is tied to 0 and any byte address passes straight through.
//
// Ports
//   clk, rst_n       clock; synchronous active-low reset
//   req_valid/ready  request handshake (accept on valid & ready)
//   req_we           1 = store, 0 = load
//   req_size         00 byte, 01 half, 10/11 word
//   req_unsigned     zero-extend loads when 1
//   req_addr         byte address
//   req_wdata        right-aligned store data
//   resp_valid       one-cycle completion pulse (registered)
//   resp_rdata       extended load data, 0 for stores (registered)
//   fault            misalignment flag qualified by resp_valid
//   mem_wr/addr/wdata  combinational drive to datamem
//   mem_rdata        combinational read data from datamem
module mem_stage_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;

  state_t      state;
  logic [31:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_half;
  logic [31:0] merge_q;
  logic [31:0] merged;
  logic        size_word;
  logic        size_half;
  logic        misaligned;

  // Size code 11 behaves exactly like a word access.
  assign size_word = req_size[1];
  assign size_half = (req_size == 2'b01);

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = (size_half & req_addr[0]) | (size_word & (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // The new bytes go at the top of the word, because the addressed byte is the MSB.
  assign merged = lat_half ? {lat_wdata[15:0], merge_q[15:0]}
                           : {lat_wdata[7:0],  merge_q[23:0]};

  function automatic logic [31:0] load_extend(input logic [31:0] d,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] r;
    case (size)
      2'b00:   r = uns ? {24'h0, d[31:24]} : {{24{d[31]}}, d[31:24]};
      2'b01:   r = uns ? {16'h0, d[31:16]} : {{16{d[31]}}, d[31:16]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Gating with rst_n keeps every output quiet while reset is held. It also stops
  // a reset that lands in RMW_WR from writing.
  always_comb begin
    // NOTE: defaults first so that no path through the case infers a latch.
    req_ready = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          req_ready = 1'b1;
          mem_addr  = req_addr;
          mem_wdata = req_wdata;
          mem_wr    = req_valid & req_we & size_word & ~misaligned;
        end
        RMW_RD: mem_addr = lat_addr;
        RMW_WR: begin
          mem_wr    = 1'b1;
          mem_addr  = lat_addr;
          mem_wdata = merged;
        end
        default: ;
      endcase
    end
  end

  // Control state and registered response.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every flop so all updates use pre-edge values.
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (!req_we) begin
              resp_valid <= 1'b1;
              resp_rdata <= load_extend(mem_rdata, req_size, req_unsigned);
            end else if (size_word) begin
              resp_valid <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        RMW_RD: state <= RMW_WR;
        RMW_WR: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          resp_rdata <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: datapath holding registers have no reset. They are only read in states
  // that are entered after they have been loaded.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid && req_we && !size_word && !misaligned) begin
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata[15:0];
      lat_half  <= size_half;
    end
    if (state == RMW_RD) merge_q <= mem_rdata;
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= (state == IDLE) & req_valid & misaligned;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu. A small big-endian byte memory
// stands in for datamem. Inputs change 1 ns after the rising edge, and outputs
// are checked from that point until the next edge.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        fault;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wr_mark;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .fault        (fault),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // datamem model: combinational big-endian read, write on the rising edge.
  assign mem_rdata = {mem[mem_addr[7:0]], mem[mem_addr[7:0] + 8'd1],
                      mem[mem_addr[7:0] + 8'd2], mem[mem_addr[7:0] + 8'd3]};

  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_addr[7:0]]        <= mem_wdata[31:24];
      mem[mem_addr[7:0] + 8'd1] <= mem_wdata[23:16];
      mem[mem_addr[7:0] + 8'd2] <= mem_wdata[15:8];
      mem[mem_addr[7:0] + 8'd3] <= mem_wdata[7:0];
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] d);
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC;
    mem[8'h13] = 8'hDD; mem[8'h14] = 8'h11;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();
    step();
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);

    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'h0, req_ready}, 32'h1);

    // Five loads back to back: LB, LBU, LH, LHU, LW at 0x10.
    step();
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    #1 check("lb_ready", {31'h0, req_ready}, 32'h1);
    step();
    check("lb_valid", {31'h0, resp_valid}, 32'h1);
    check("lb_data", resp_rdata, 32'hFFFFFFAA);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    step();
    check("lbu_valid", {31'h0, resp_valid}, 32'h1);
    check("lbu_data", resp_rdata, 32'h000000AA);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    step();
    check("lh_valid", {31'h0, resp_valid}, 32'h1);
    check("lh_data", resp_rdata, 32'hFFFFAABB);
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    step();
    check("lhu_valid", {31'h0, resp_valid}, 32'h1);
    check("lhu_data", resp_rdata, 32'h0000AABB);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    step();
    check("lw_valid", {31'h0, resp_valid}, 32'h1);
    check("lw_data", resp_rdata, 32'hAABBCCDD);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();
    check("loads_done_valid", {31'h0, resp_valid}, 32'h0);

    // Byte store at 0x11: RMW, single write at N+2.
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055);
    wr_mark = wr_count;
    #1;
    check("sb_accept_ready", {31'h0, req_ready}, 32'h1);
    check("sb_accept_wr", {31'h0, mem_wr}, 32'h0);
    step();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1;
    check("sb_n1_ready", {31'h0, req_ready}, 32'h0);
    check("sb_n1_wr", {31'h0, mem_wr}, 32'h0);
    check("sb_n1_valid", {31'h0, resp_valid}, 32'h0);
    step();
    check("sb_n2_ready", {31'h0, req_ready}, 32'h0);
    check("sb_n2_wr", {31'h0, mem_wr}, 32'h1);
    check("sb_n2_addr", mem_addr, 32'h11);
    check("sb_n2_wdata", mem_wdata, 32'h55CCDD11);
    step();
    check("sb_n3_valid", {31'h0, resp_valid}, 32'h1);
    check("sb_n3_rdata", resp_rdata, 32'h0);
    check("sb_n3_ready", {31'h0, req_ready}, 32'h1);
    check("sb_wr_pulses", wr_count - wr_mark, 32'd1);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    step();
    check("sb_readback", resp_rdata, 32'hAA55CCDD);

    // Word store at 0x20.
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    #1;
    check("sw_wr", {31'h0, mem_wr}, 32'h1);
    check("sw_addr", mem_addr, 32'h20);
    check("sw_wdata", mem_wdata, 32'h12345678);
    step();
    check("sw_valid", {31'h0, resp_valid}, 32'h1);
    check("sw_rdata", resp_rdata, 32'h0);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    step();
    check("sw_readback", resp_rdata, 32'h12345678);

    // Restore 0x10..0x13, then reset in the middle of an SH.
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hAABBCCDD);
    step();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    step();
    check("pre_sh_load", resp_rdata, 32'h12345678);
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF);
    wr_mark = wr_count;
    step();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1;
    check("rmw_rst_ready", {31'h0, req_ready}, 32'h0);
    check("rmw_rst_wr", {31'h0, mem_wr}, 32'h0);
    check("rmw_rst_addr", mem_addr, 32'h0);
    step();
    check("rmw_rst_valid", {31'h0, resp_valid}, 32'h0);
    check("rmw_rst_rdata", resp_rdata, 32'h0);
    check("rmw_rst_fault", {31'h0, fault}, 32'h0);
    check("rmw_rst_wr2", {31'h0, mem_wr}, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("rmw_post_ready", {31'h0, req_ready}, 32'h1);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    step();
    check("rmw_abandon_data", resp_rdata, 32'hAABBCCDD);
    check("rmw_abandon_wr", wr_count - wr_mark, 32'd0);

`ifdef LSU_ALIGN_CHECK_EN
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    step();
    check("lh_mis_valid", {31'h0, resp_valid}, 32'h1);
    check("lh_mis_fault", {31'h0, fault}, 32'h1);
    check("lh_mis_rdata", resp_rdata, 32'h0);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h22, 32'hDEADBEEF);
    #1 check("sw_mis_wr", {31'h0, mem_wr}, 32'h0);
    step();
    check("sw_mis_fault", {31'h0, fault}, 32'h1);
    check("sw_mis_valid", {31'h0, resp_valid}, 32'h1);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    step();
    check("sw_mis_mem", resp_rdata, 32'h12345678);
    check("sw_mis_fault_clr", {31'h0, fault}, 32'h0);
`else
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
    step();
    check("lw_unaligned", resp_rdata, 32'hBBCCDD11);
    check("lw_unaligned_fault", {31'h0, fault}, 32'h0);
`endif

    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();
    check("final_idle", {31'h0, resp_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM pipeline stage, between the EX/MEM pipeline register and `datamem`. Converts byte, halfword and word load/store requests into the big-endian, byte-addressed 32-bit word port of `datamem`. Loads are sign- or zero-extended. Sub-word stores use a registered read-modify-write sequence, and the unit stalls the pipeline while that sequence runs.

## Interface
- No parameters; widths fixed at 32-bit address and data.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: pipeline presents a memory operation.
- `req_ready` out 1: request accepted on a cycle where `req_valid & req_ready`; otherwise the pipeline stalls.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: access size.
  - 00 = byte, 01 = half, 10 = word.
  - 11 = treated as word.
- `req_unsigned` in 1: zero-extend loads when 1, sign-extend when 0.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle pulse per completed request; there is no backpressure.
- `resp_rdata` out 32: extended load result; 0 for stores.
- `fault` out 1: misalignment flag, qualified by `resp_valid`.
- `mem_wr` out 1: to `datamem` `data_wr`.
- `mem_addr` out 32: to `datamem` `data_addr`.
- `mem_wdata` out 32: to `datamem` `data_in`.
- `mem_rdata` in 32: from `datamem` `data_out`; combinational read of bytes addr..addr+3, MSB first.

## Operation
- FSM states:
  - `IDLE`
  - `RMW_RD`
  - `RMW_WR`
- **IDLE**
  - `req_ready` = 1.
  - `mem_addr` = `req_addr`.
  - `mem_wr` = `req_valid & req_we & (size is word)`.
  - `mem_wdata` = `req_wdata`.
- **Load accepted**
  - `mem_rdata` is sampled at the accepting edge.
  - Byte: result is `[31:24]`, extended to 32 bits.
  - Half: result is `[31:16]`, extended.
  - Word: result is all 32 bits, unmodified.
  - State stays in `IDLE`.
- **Word store accepted:** `datamem` is written at the accepting edge. State stays in `IDLE`.
- **Byte/half store accepted**
  - `req_addr`, `req_wdata` and `req_size` are latched.
  - `mem_wr` = 0.
  - Next state is `RMW_RD`.
- **RMW_RD**
  - `req_ready` = 0.
  - `mem_addr` = latched address.
  - `mem_rdata` is captured into the merge register.
  - Next state is `RMW_WR`.
- **RMW_WR**
  - `req_ready` = 0.
  - `mem_wr` = 1; `mem_addr` = latched address.
  - `mem_wdata` = merge register with `[31:24]` replaced by `wdata[7:0]` (byte), or `[31:16]` replaced by `wdata[15:0]` (half).
  - Next state is `IDLE`.
- `req_*` inputs are don't-care while `req_ready` = 0. The requester holds the request until it is accepted.
- No address range check; `mem_addr` carries all 32 bits unchanged, with no wrap handling in this block.
- Reset:
  - `rst_n` low forces state to `IDLE`.
  - `mem_wr` = 0, `req_ready` = 0, `resp_valid` = 0, `resp_rdata` = 0, `fault` = 0.
  - Reset mid-RMW abandons the operation with no write.
  - `req_ready` = 1 on the first cycle after `rst_n` goes high.

## Timing
- Load or word store accepted at cycle N: `resp_valid` at N+1; a load's `resp_rdata` is valid at N+1.
- Loads and word stores sustain one request per cycle back-to-back.
- Sub-word store accepted at N:
  - `req_ready` low at N+1 and N+2.
  - Single `mem_wr` pulse at N+2.
  - `resp_valid` at N+3.
  - Next request accepted at N+3 at the earliest.
- A load accepted at N+3 observes the RMW write.
- `resp_valid`, `resp_rdata` and `fault` are registered.
- `mem_*` outputs are combinational from state and latched or request fields.

## Configuration
- Macro `LSU_ALIGN_CHECK_EN`.
- **Defined**
  - A half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0, is misaligned.
  - A misaligned request is accepted in one cycle.
  - `mem_wr` is never asserted for it.
  - At N+1: `resp_valid` = 1, `fault` = 1, `resp_rdata` = 0.
- **Undefined**
  - `fault` is tied to 0.
  - Misaligned accesses pass through unchanged; `datamem` serves arbitrary byte addresses.

## Test plan
Common preload: memory 0x10..0x14 = AA BB CC DD 11.
- **Loads:** LB signed at 0x10 -> 0xFFFFFFAA at N+1. LBU at 0x10 -> 0x000000AA. LH at 0x10 -> 0xFFFFAABB. LHU at 0x10 -> 0x0000AABB. LW at 0x10 -> 0xAABBCCDD. Issued back-to-back, there are five `resp_valid` pulses on consecutive cycles.
- **Byte store:** SB at 0x11 with wdata 0x00000055.
  - `req_ready` low for 2 cycles.
  - One `mem_wr` pulse at N+2 with `mem_addr` 0x11 and `mem_wdata` 0x55CCDD11.
  - A following LW at 0x10 -> 0xAA55CCDD.
- **Word store:** SW at 0x20 with wdata 0x12345678.
  - `mem_wr` in the accept cycle.
  - `resp_valid` at N+1 with `resp_rdata` 0.
  - LW at 0x20 -> 0x12345678.
- **Reset during RMW:** `rst_n` low during `RMW_RD` of SH at 0x10 with wdata 0xBEEF.
  - `mem_wr` never asserted.
  - LW at 0x10 after reset -> 0xAABBCCDD.
  - All outputs 0 during reset.
  - `req_ready` = 1 on the first cycle after reset.
- **Alignment:**
  - With `LSU_ALIGN_CHECK_EN`: LH at 0x13 -> `fault` = 1, `resp_rdata` 0. SW at 0x22 -> `fault` = 1 and memory unchanged.
  - Without the macro: LW at 0x11 -> 0xBBCCDD11 with `fault` = 0.
